// File: rtl/auth_ctrl_param.sv
// Parametrised user ID / password authentication controller.
// Reads the stored password from an external synchronous ROM, tracks failed attempts and enforces a timed lockout.
module auth_ctrl_param #(
  parameter int ID_W        = 4,
  parameter int PW_W        = 4,
  parameter int NUM_USERS   = 16,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int DENY_CYC    = 50,
  parameter int LOCK_CYC    = 5000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ID_W-1:0]                in_toggle_userid,
  input  logic [PW_W-1:0]                in_toggle_pswd,
  input  logic                           userid_btn,
  input  logic                           pswd_btn,
  input  logic                           logout_btn,
  output logic                           rom_rd,
  output logic [ID_W-1:0]                rom_addr,
  input  logic [PW_W-1:0]                rom_data,
  output logic [ID_W-1:0]                internalid,
  output logic                           authorise_bit,
  output logic                           greenled,
  output logic                           redled,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int CNT_MAX = (LOCK_CYC > TIMEOUT_CYC)
                           ? ((LOCK_CYC > DENY_CYC) ? LOCK_CYC : DENY_CYC)
                           : ((TIMEOUT_CYC > DENY_CYC) ? TIMEOUT_CYC : DENY_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_PSWD = 3'd1;
  localparam logic [2:0] CHECK     = 3'd2;
  localparam logic [2:0] COMPARE   = 3'd3;
  localparam logic [2:0] GRANTED   = 3'd4;
  localparam logic [2:0] DENIED    = 3'd5;
  localparam logic [2:0] LOCKED    = 3'd6;

  logic [2:0]       state, state_d;
  logic [PW_W-1:0]  pw_q;
  logic [CNT_W-1:0] cnt;
  logic             id_ok, last_try;
  logic             id_ld, pw_ld, cnt_clr, fc_inc, fc_clr;

  assign id_ok    = int'(in_toggle_userid) < NUM_USERS;
  assign last_try = int'(fail_count) == MAX_TRIES - 1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state;
    id_ld   = 1'b0;
    pw_ld   = 1'b0;
    cnt_clr = 1'b0;
    fc_inc  = 1'b0;
    fc_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (userid_btn) begin
          if (id_ok) begin
            id_ld   = 1'b1;
            state_d = WAIT_PSWD;
          end else begin
            state_d = DENIED;
          end
        end
      end
      WAIT_PSWD: begin
        if (logout_btn) begin
          state_d = IDLE;
        end else if (pswd_btn) begin
          pw_ld   = 1'b1;
          state_d = CHECK;
        end else if (userid_btn) begin
          if (id_ok) begin
            id_ld   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_d = DENIED;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      CHECK:   state_d = COMPARE;
      COMPARE: begin
        if (rom_data == pw_q) begin
          fc_clr  = 1'b1;
          state_d = GRANTED;
        end else begin
          fc_inc  = 1'b1;
          state_d = last_try ? LOCKED : DENIED;
        end
      end
      GRANTED: if (logout_btn) state_d = IDLE;
      DENIED:  if (cnt == CNT_W'(DENY_CYC - 1)) state_d = IDLE;
      LOCKED: begin
        if (cnt == CNT_W'(LOCK_CYC - 1)) begin
          fc_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // One shared counter times WAIT_PSWD, DENIED and LOCKED; it restarts on every state change.
    if (state_d != state) cnt_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      internalid <= '0;
      pw_q       <= '0;
      cnt        <= '0;
      fail_count <= '0;
    end else begin
      state <= state_d;
      if (id_ld) internalid <= in_toggle_userid;
      if (pw_ld) pw_q <= in_toggle_pswd;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt != CNT_W'(CNT_MAX))
        cnt <= cnt + 1'b1;
      if (fc_clr)
        fail_count <= '0;
      else if (fc_inc && fail_count != FC_W'(MAX_TRIES))
        fail_count <= fail_count + 1'b1;
    end
  end

  assign rom_rd        = (state == CHECK);
  assign rom_addr      = internalid;
  assign authorise_bit = (state == GRANTED);
  assign greenled      = (state == GRANTED);
  assign redled        = (state == DENIED) || (state == LOCKED);
  assign locked        = (state == LOCKED);

endmodule

// File: tb/tb_auth_ctrl_param.sv
// Scoreboard bench for auth_ctrl_param: stimulus queues expectations, a negedge monitor pops and compares.
module tb_auth_ctrl_param;

  localparam int ID_W = 4;
  localparam int PW_W = 4;
  localparam int FC_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [ID_W-1:0] in_toggle_userid;
  logic [PW_W-1:0] in_toggle_pswd;
  logic            userid_btn, pswd_btn, logout_btn;
  logic            rom_rd;
  logic [ID_W-1:0] rom_addr;
  logic [PW_W-1:0] rom_data = '0;
  logic [ID_W-1:0] internalid;
  logic            authorise_bit, greenled, redled, locked;
  logic [FC_W-1:0] fail_count;

  auth_ctrl_param #(.ID_W(ID_W), .PW_W(PW_W), .NUM_USERS(10), .MAX_TRIES(3),
                    .TIMEOUT_CYC(1000), .DENY_CYC(50), .LOCK_CYC(5000)) dut (
    .clk(clk), .reset(reset),
    .in_toggle_userid(in_toggle_userid), .in_toggle_pswd(in_toggle_pswd),
    .userid_btn(userid_btn), .pswd_btn(pswd_btn), .logout_btn(logout_btn),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .internalid(internalid), .authorise_bit(authorise_bit), .greenled(greenled),
    .redled(redled), .locked(locked), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  logic [PW_W-1:0] rom_mem [16];
  always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  // Output vector order: {authorise_bit, greenled, redled, locked, rom_rd}
  typedef struct packed { logic [4:0] vec; logic [ID_W-1:0] id; logic [FC_W-1:0] fc; } probe_t;
  typedef struct packed { logic lock; logic [15:0] len; logic [FC_W-1:0] fc_in; logic [FC_W-1:0] fc_out; } red_t;

  probe_t          probe_q[$];
  red_t            red_q[$];
  logic [ID_W-1:0] read_q[$];
  logic            probe_req = 1'b0;
  int              n_cmp = 0;
  int              n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
  endtask

  // Monitor
  logic            red_prev = 1'b0;
  logic            red_lock;
  logic [15:0]     red_len;
  logic [FC_W-1:0] red_fc;
  always @(negedge clk) begin
    if (probe_req) begin
      if (probe_q.size() == 0) unexpected("probe");
      else check("probe", 32'({authorise_bit, greenled, redled, locked, rom_rd, internalid, fail_count}),
                 32'(probe_q.pop_front()));
    end
    if (rom_rd) begin
      if (read_q.size() == 0) unexpected("rom_read");
      else check("rom_addr", 32'(rom_addr), 32'(read_q.pop_front()));
    end
    if (redled) begin
      if (!red_prev) begin
        red_len  = 16'd0;
        red_lock = 1'b0;
        red_fc   = fail_count;
      end
      red_len++;
      red_lock |= locked;
    end else if (red_prev) begin
      if (red_q.size() == 0) unexpected("red_pulse");
      else check("red_pulse", 32'({red_lock, red_len, red_fc, fail_count}), 32'(red_q.pop_front()));
    end
    red_prev = redled;
  end

  // Stimulus helpers: each starts and ends just after a falling edge.
  task automatic step_probe(input logic [4:0] vec, input logic [ID_W-1:0] id, input logic [FC_W-1:0] fc);
    @(posedge clk);
    probe_q.push_back('{vec: vec, id: id, fc: fc});
    probe_req = 1'b1;
    @(negedge clk);
    #1 probe_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_uid(input logic [ID_W-1:0] id);
    in_toggle_userid = id;
    userid_btn = 1'b1;
    idle_cycles(1);
    userid_btn = 1'b0;
  endtask

  task automatic press_pswd(input logic [PW_W-1:0] pw);
    in_toggle_pswd = pw;
    pswd_btn = 1'b1;
    idle_cycles(1);
    pswd_btn = 1'b0;
  endtask

  task automatic press_logout();
    logout_btn = 1'b1;
    idle_cycles(1);
    logout_btn = 1'b0;
  endtask

  task automatic push_red(input logic lock, input int len, input logic [FC_W-1:0] fc_in,
                          input logic [FC_W-1:0] fc_out);
    red_q.push_back('{lock: lock, len: 16'(len), fc_in: fc_in, fc_out: fc_out});
  endtask

  task automatic wrong_attempt(input logic [ID_W-1:0] id, input logic [PW_W-1:0] pw,
                               input logic [FC_W-1:0] fc_new);
    press_uid(id);
    read_q.push_back(id);
    push_red(1'b0, 50, fc_new, fc_new);
    press_pswd(pw);
    idle_cycles(60);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'hF;
    rom_mem[5] = 4'hA;
    rom_mem[2] = 4'h7;
    rom_mem[9] = 4'h6;
    reset = 1'b0;
    in_toggle_userid = '0;
    in_toggle_pswd   = '0;
    userid_btn = 1'b0;
    pswd_btn   = 1'b0;
    logout_btn = 1'b0;
    idle_cycles(2);
    step_probe(5'b00000, 4'd0, 2'd0);
    reset = 1'b1;
    idle_cycles(2);

    // Valid login with latency checks, then logout
    press_uid(4'd5);
    read_q.push_back(4'd5);
    in_toggle_pswd = 4'hA;
    pswd_btn = 1'b1;
    step_probe(5'b00001, 4'd5, 2'd0);
    pswd_btn = 1'b0;
    step_probe(5'b00000, 4'd5, 2'd0);
    step_probe(5'b11000, 4'd5, 2'd0);
    logout_btn = 1'b1;
    step_probe(5'b00000, 4'd5, 2'd0);
    logout_btn = 1'b0;

    // Wrong passwords: two denials, the third locks
    wrong_attempt(4'd5, 4'h3, 2'd1);
    step_probe(5'b00000, 4'd5, 2'd1);
    wrong_attempt(4'd5, 4'h3, 2'd2);
    press_uid(4'd5);
    read_q.push_back(4'd5);
    push_red(1'b1, 5000, 2'd3, 2'd0);
    press_pswd(4'h3);
    idle_cycles(2);
    step_probe(5'b00110, 4'd5, 2'd3);
    press_uid(4'd2);
    press_pswd(4'h7);
    press_logout();
    idle_cycles(5010);
    step_probe(5'b00000, 4'd5, 2'd0);

    // Timeout: password press one cycle too late is ignored, fail_count kept
    wrong_attempt(4'd2, 4'h0, 2'd1);
    press_uid(4'd2);
    idle_cycles(1000);
    press_pswd(4'h7);
    step_probe(5'b00000, 4'd2, 2'd1);

    // Invalid IDs, from IDLE and from WAIT_PSWD (NUM_USERS = 10)
    push_red(1'b0, 50, 2'd1, 2'd1);
    press_uid(4'd12);
    idle_cycles(60);
    press_uid(4'd5);
    push_red(1'b0, 50, 2'd1, 2'd1);
    press_uid(4'd10);
    idle_cycles(60);
    step_probe(5'b00000, 4'd5, 2'd1);

    // Password on the last cycle before timeout is still accepted
    press_uid(4'd2);
    idle_cycles(999);
    read_q.push_back(4'd2);
    press_pswd(4'h7);
    step_probe(5'b00000, 4'd2, 2'd1);
    step_probe(5'b11000, 4'd2, 2'd0);
    logout_btn = 1'b1;
    step_probe(5'b00000, 4'd2, 2'd0);
    logout_btn = 1'b0;

    // logout beats pswd in WAIT_PSWD; a later pswd in IDLE is ignored
    press_uid(4'd9);
    logout_btn = 1'b1;
    in_toggle_pswd = 4'h6;
    pswd_btn = 1'b1;
    step_probe(5'b00000, 4'd9, 2'd0);
    logout_btn = 1'b0;
    pswd_btn = 1'b0;
    press_pswd(4'h6);
    step_probe(5'b00000, 4'd9, 2'd0);

    // Reset during COMPARE clears everything
    wrong_attempt(4'd9, 4'h0, 2'd1);
    press_uid(4'd9);
    read_q.push_back(4'd9);
    press_pswd(4'h6);
    step_probe(5'b00000, 4'd9, 2'd1);
    reset = 1'b0;
    step_probe(5'b00000, 4'd0, 2'd0);
    reset = 1'b1;
    idle_cycles(5);
    step_probe(5'b00000, 4'd0, 2'd0);

    idle_cycles(5);
    check("drain_probe", 32'(probe_q.size()), 32'd0);
    check("drain_read", 32'(read_q.size()), 32'd0);
    check("drain_red", 32'(red_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/auth_ctrl_param.md
Name: auth_ctrl_param

Overview:
- Parametrised successor of the userid/password authentication top.
- Accepts a user ID and a password from toggle switches, each qualified by a pre-shaped button pulse.
- Looks the stored password up in an external synchronous ROM and drives the authorise bit and the red/green LEDs.
- Adds over the previous generation: configurable widths and user count, password-entry timeout, failed-attempt counting with timed lockout, and an explicit ROM read handshake.

Parameters:
- ID_W, 4, width of user ID toggles and internalid.
- PW_W, 4, width of password toggles and ROM data.
- NUM_USERS, 16, valid IDs are 0..NUM_USERS-1 (NUM_USERS <= 2**ID_W).
- MAX_TRIES, 3, consecutive failed password checks that trigger lockout (>= 1).
- TIMEOUT_CYC, 1000, cycles allowed in WAIT_PSWD without a password press.
- DENY_CYC, 50, cycles redled is held after a denial.
- LOCK_CYC, 5000, lockout duration in cycles.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- reset, input, 1, synchronous, active-low reset.
- in_toggle_userid, input, ID_W, user ID switches.
- in_toggle_pswd, input, PW_W, password switches.
- userid_btn, input, 1, one-cycle pulse from ButtonShaper.
- pswd_btn, input, 1, one-cycle pulse from ButtonShaper.
- logout_btn, input, 1, one-cycle pulse.
- rom_rd, output, 1, ROM read strobe.
- rom_addr, output, ID_W, ROM address; always equals internalid.
- rom_data, input, PW_W, stored password; valid the cycle after rom_rd.
- internalid, output, ID_W, latched user ID.
- authorise_bit, output, 1, access granted.
- greenled, output, 1, granted indicator.
- redled, output, 1, denied/locked indicator.
- locked, output, 1, lockout active.
- fail_count, output, $clog2(MAX_TRIES+1), consecutive failures.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - internalid, fail_count, the password latch and the timeout/hold counters clear to 0.
  - All 1-bit outputs are 0.
  - Reset overrides every state, including mid-CHECK and LOCKED.
- All outputs are registered or decoded from the state register; no input-to-output combinational path.

States:
- IDLE:
  - On userid_btn with in_toggle_userid < NUM_USERS: latch the ID into internalid, clear the timeout counter, go to WAIT_PSWD.
  - On userid_btn with an ID >= NUM_USERS: go to DENIED; fail_count is unchanged.
  - pswd_btn and logout_btn are ignored.
- WAIT_PSWD: priority is logout_btn, then pswd_btn, then userid_btn, then timeout.
  - logout_btn: go to IDLE (abort).
  - pswd_btn: latch in_toggle_pswd, go to CHECK.
  - userid_btn with a valid ID: re-latch internalid and restart the timeout. With an invalid ID: go to DENIED.
  - Timeout counter reaching TIMEOUT_CYC-1: go to IDLE with no failure counted.
- CHECK (1 cycle): rom_rd=1, rom_addr=internalid; always go to COMPARE.
- COMPARE (1 cycle): compare rom_data with the latched password (full PW_W-bit equality).
  - Match: fail_count=0, go to GRANTED.
  - Mismatch with fail_count+1 == MAX_TRIES: increment fail_count, go to LOCKED.
  - Mismatch otherwise: increment fail_count, go to DENIED.
- GRANTED: authorise_bit=1, greenled=1. On logout_btn, go to IDLE; all other buttons are ignored.
- DENIED: redled=1 for exactly DENY_CYC cycles, then IDLE. All buttons are ignored.
- LOCKED: redled=1 and locked=1 for exactly LOCK_CYC cycles, then clear fail_count and go to IDLE. All buttons are ignored.
- Buttons are ignored in CHECK and COMPARE, including logout_btn.

Timing and counters:
- Latency: pswd_btn sampled at edge t puts the block in CHECK for cycle t+1 and COMPARE for t+2. GRANTED, DENIED or LOCKED outputs are visible from t+3.
- fail_count is global, not per user. It persists across DENIED→IDLE and across ID changes, and clears only on success, lockout expiry or reset.
- Counters saturate; they never wrap.

Test Plan:
- Reset, then valid login: reset low 2 cycles; rom[5]=4'hA; ID=5 with userid_btn, pswd=4'hA with pswd_btn → rom_rd=1 with rom_addr=5 at t+1; greenled=authorise_bit=1 from t+3; fail_count=0; logout_btn returns to IDLE with all outputs 0.
- Wrong password: pswd=4'h3 against rom[5]=4'hA → redled=1 for exactly 50 cycles, fail_count=1, then IDLE.
- Lockout: three consecutive wrong passwords → third yields locked=1 and redled=1 for 5000 cycles with all buttons ignored; afterwards fail_count=0 and state IDLE.
- Timeout: userid_btn with ID=2, no pswd_btn for 1000 cycles → IDLE; fail_count unchanged; a later pswd_btn is ignored.
- Invalid ID with NUM_USERS=10: ID=12 → DENIED 50 cycles, rom_rd never asserted, fail_count unchanged.
- Priority/reset corners: logout_btn and pswd_btn in the same cycle in WAIT_PSWD → IDLE with no ROM read; reset asserted during COMPARE → all outputs 0 next cycle.
